ocm_s2_stream_reader: RTL and testbench

- DMA-style drain engine on the 64-bit s2 port of the on-chip memory in the qtest system.
- Reads a word-aligned region and serialises it little-endian into a byte stream with valid/ready handshake.
- Consumes what the 8-bit s1 side (or any s2 writer) has placed in memory.
- s1 byte address = s2 word address * 8 + byte lane, so stream order matches s1 byte order.

---
 rtl/ocm_stream_pkg.sv | 23 ++
 rtl/ocm_word_fifo.sv | 47 ++++
 rtl/ocm_s2_stream_reader.sv | 171 +++++++++++++++++
 tb/tb_ocm_s2_stream_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ocm_stream_pkg.sv
// Shared widths, state encoding and helpers for the on-chip-memory s2 stream reader.
package ocm_stream_pkg;

    localparam int OCM_WORD_ADDR_W = 14;
    localparam int OCM_BYTE_LEN_W  = 17;
    localparam int OCM_DATA_W      = 64;
    localparam int OCM_LANES       = 8;
    // ceil(131071/8) = 16384 needs 15 bits
    localparam int OCM_WORD_CNT_W  = OCM_BYTE_LEN_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rd_state_t;

    function automatic logic [OCM_WORD_CNT_W-1:0] words_for_len(input logic [OCM_BYTE_LEN_W-1:0] len);
        logic [OCM_BYTE_LEN_W:0] sum;
        sum = {1'b0, len} + (OCM_BYTE_LEN_W+1)'(7);
        return sum[OCM_BYTE_LEN_W:3];
    endfunction

endpackage

// File: rtl/ocm_word_fifo.sv
// Show-ahead word FIFO between the memory read return path and the byte serialiser.
module ocm_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ocm_s2_stream_reader.sv
// Drains a word-aligned region of the 64-bit s2 port into a little-endian byte stream.
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | issuing reads and emitting bytes
//   FINISH | one-cycle done pulse, then back to IDLE
module ocm_s2_stream_reader
    import ocm_stream_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       start,
    input  logic [OCM_WORD_ADDR_W-1:0] base_addr,
    input  logic [OCM_BYTE_LEN_W-1:0]  byte_len,
    output logic                       busy,
    output logic                       done,
    output logic [OCM_WORD_ADDR_W-1:0] mem_address,
    output logic                       mem_chipselect,
    output logic                       mem_clken,
    output logic                       mem_write,
    output logic [OCM_DATA_W-1:0]      mem_writedata,
    output logic [OCM_LANES-1:0]       mem_byteenable,
    input  logic [OCM_DATA_W-1:0]      mem_readdata,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 2);
    localparam int LANE_W = $clog2(OCM_LANES);

    rd_state_t                  state, state_n;
    logic                       accept;
    logic                       busy_q, done_q;

    logic [OCM_WORD_ADDR_W-1:0] ptr_q, addr_q;
    logic [OCM_WORD_CNT_W-1:0]  words_left_q;
    logic                       cs_q;
    logic [READ_LATENCY-1:0]    vld_q;
    logic [OUT_W-1:0]           vld_cnt, outstanding;
    logic                       issue;

    logic [OCM_BYTE_LEN_W-1:0]  bytes_left_q, bl_after;
    logic [OCM_DATA_W-1:0]      sh_q;
    logic [LANE_W-1:0]          lane_q;
    logic                       valid_q, last_q;
    logic                       hs, word_end, load;

    logic [OCM_DATA_W-1:0]      fifo_rdata;
    logic [CNT_W-1:0]           fifo_count;

    ocm_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OCM_DATA_W)
    ) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (vld_q[READ_LATENCY-1]),
        .wdata (mem_readdata),
        .pop   (load),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == RUN);
            done_q <= (state_n == FINISH);
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = (byte_len == '0) ? FINISH : RUN;
                end
            end
            RUN:     if (hs && last_q) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Counting the presented request and the in-flight reads keeps FIFO entries reserved.
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++) vld_cnt = vld_cnt + OUT_W'(vld_q[i]);
        outstanding = OUT_W'(fifo_count) + vld_cnt + OUT_W'(cs_q);
        issue = (state == RUN) && (words_left_q != '0) && (outstanding < OUT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ptr_q        <= '0;
            addr_q       <= '0;
            words_left_q <= '0;
            cs_q         <= 1'b0;
            vld_q        <= '0;
        end else begin
            cs_q  <= issue;
            vld_q <= (vld_q << 1) | READ_LATENCY'(cs_q);
            if (accept) begin
                ptr_q        <= base_addr;
                words_left_q <= words_for_len(byte_len);
            end else if (issue) begin
                addr_q       <= ptr_q;
                ptr_q        <= ptr_q + OCM_WORD_ADDR_W'(1);
                words_left_q <= words_left_q - OCM_WORD_CNT_W'(1);
            end
        end
    end

    always_comb begin
        hs       = valid_q & m_ready;
        bl_after = bytes_left_q - OCM_BYTE_LEN_W'(hs);
        word_end = hs & ((lane_q == LANE_W'(OCM_LANES - 1)) | (bytes_left_q == OCM_BYTE_LEN_W'(1)));
        load     = (state == RUN) & (~valid_q | word_end) & (fifo_count != '0) & (bl_after != '0);
    end

    // The shift register's low byte is the presented byte, so m_data comes straight off a flop.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bytes_left_q <= '0;
            sh_q         <= '0;
            lane_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            if (accept)  bytes_left_q <= byte_len;
            else if (hs) bytes_left_q <= bl_after;

            if (load) begin
                sh_q    <= fifo_rdata;
                lane_q  <= '0;
                valid_q <= 1'b1;
                last_q  <= (bl_after == OCM_BYTE_LEN_W'(1));
            end else if (hs) begin
                sh_q    <= sh_q >> 8;
                lane_q  <= lane_q + LANE_W'(1);
                valid_q <= ~word_end;
                last_q  <= ~word_end & (bl_after == OCM_BYTE_LEN_W'(1));
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_clken      = busy_q;
    assign mem_write      = 1'b0;
    assign mem_writedata  = '0;
    assign mem_byteenable = '1;
    assign m_data         = sh_q[7:0];
    assign m_valid        = valid_q;
    assign m_last         = last_q;

endmodule

// File: tb/tb_ocm_s2_stream_reader.sv
// Directed bench for the s2 stream reader: memory model, byte scoreboard and per-cycle stream monitor.
module tb_ocm_s2_stream_reader;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [16:0] byte_len = '0;
    logic        busy, done;
    logic [13:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [63:0] mem_writedata;
    logic [7:0]  mem_byteenable;
    logic [63:0] mem_readdata;
    logic [7:0]  m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;

    always #5 clk_clk = ~clk_clk;

    logic [63:0] mem [16384];
    logic [63:0] rd_q = '0;
    always @(posedge clk_clk) if (mem_chipselect) rd_q <= mem[mem_address];
    assign mem_readdata = rd_q;

    ocm_s2_stream_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .byte_len       (byte_len),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last)
    );

    int n_pass = 0, n_chk = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int cs_cnt, hs_cnt, done_cnt, done_cyc, first_hs_cyc, last_hs_cyc, first_valid_cyc, max_out;
    int ready_mode = 0;
    bit busy_seen, cs_seen, valid_seen, check_out = 0;
    bit prev_stall = 0;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [13:0] addr_log[$];
    logic [8:0]  exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        int outst;
        logic [8:0] e;
        if (mem_chipselect) begin
            cs_cnt++;
            cs_seen = 1;
            addr_log.push_back(mem_address);
        end
        if (busy) busy_seen = 1;
        if (m_valid) begin
            valid_seen = 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (check_out) begin
            outst = cs_cnt - (hs_cnt / 8 + int'(m_valid));
            if (outst > max_out) max_out = outst;
            chk("outstanding_le_4", outst <= 4, 1);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_byte_sb_size", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("byte", m_data, e[7:0]);
                chk("last", m_last, e[8]);
            end
            if (hs_cnt == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic step();
        @(negedge clk_clk);
        cyc++;
        if (ready_mode == 0) m_ready = 1'b1;
        else if (first_valid_cyc < 0 || cyc < first_valid_cyc + 20) m_ready = 1'b0;
        else m_ready = 1'($urandom_range(0, 1));
        monitor();
    endtask

    task automatic start_xfer(input logic [13:0] base, input int len, input int mode);
        logic [63:0] w;
        exp_q.delete();
        addr_log.delete();
        cs_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_hs_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1; max_out = 0;
        busy_seen = 0; cs_seen = 0; valid_seen = 0;
        for (int i = 0; i < len; i++) begin
            w = mem[14'(base + 14'(i / 8))];
            exp_q.push_back({i == len - 1, w[8 * (i % 8) +: 8]});
        end
        ready_mode = mode;
        m_ready    = (mode == 0);
        base_addr  = base;
        byte_len   = 17'(len);
        start      = 1'b1;
        start_cyc  = cyc;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++)
            mem[i] = {16'(i), 16'(i ^ 16'hA5A5), 16'(~i), 16'(i * 3 + 1)};
        mem[16'h0010] = 64'h0706050403020100;
        mem[16'h0011] = 64'h0F0E0D0C0B0A0908;

        // reset state
        step(); step(); step();
        chk("rst_ctrl", {busy, done, mem_chipselect, mem_clken, m_valid, m_last}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_data", m_data, 0);
        chk("const_write", {mem_write, mem_byteenable}, 9'h0FF);
        chk("const_wdata", (mem_writedata == 64'h0), 1);
        reset_reset_n = 1'b1;
        step(); step();

        // basic 16-byte transfer, with a start pulse mid-run that must be ignored
        start_xfer(14'h0010, 16, 0);
        chk("basic_busy_early", busy, 1);
        chk("basic_clken", mem_clken, 1);
        step(); step();
        start = 1'b1; base_addr = 14'h0000; byte_len = 17'd5;
        step();
        start = 1'b0;
        wait_done("basic", 200);
        chk("basic_cs_count", cs_cnt, 2);
        chk("basic_consecutive", last_hs_cyc - first_hs_cyc, 15);
        chk("basic_done_after_last", done_cyc - last_hs_cyc, 1);
        chk("basic_byte_count", hs_cnt, 16);

        // partial word
        start_xfer(14'h0010, 3, 0);
        wait_done("partial", 200);
        chk("partial_cs_count", cs_cnt, 1);
        chk("partial_byte_count", hs_cnt, 3);

        // empty transfer
        start_xfer(14'h0010, 0, 0);
        wait_done("empty", 20);
        chk("empty_done_cycle", done_cyc - start_cyc, 1);
        chk("empty_busy_seen", busy_seen, 0);
        chk("empty_cs_seen", cs_seen, 0);
        chk("empty_valid_seen", valid_seen, 0);

        // backpressure
        check_out = 1;
        start_xfer(14'h0100, 64, 1);
        wait_done("bp", 3000);
        check_out = 0;
        chk("bp_cs_count", cs_cnt, 8);
        chk("bp_max_outstanding", max_out, 4);
        chk("bp_byte_count", hs_cnt, 64);
        ready_mode = 0;

        // address wrap
        start_xfer(14'h3FFF, 16, 0);
        wait_done("wrap", 200);
        chk("wrap_addr_count", addr_log.size(), 2);
        if (addr_log.size() >= 2) begin
            chk("wrap_addr0", addr_log[0], 14'h3FFF);
            chk("wrap_addr1", addr_log[1], 14'h0000);
        end

        // asynchronous reset in the middle of a transfer
        start_xfer(14'h0020, 32, 0);
        for (int n = 0; n < 100 && hs_cnt < 5; n++) step();
        chk("mid_reach_5_bytes", hs_cnt >= 5, 1);
        reset_reset_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {busy, done, mem_chipselect, mem_clken, m_valid, m_last}, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_data", m_data, 0);
        step(); step(); step();
        reset_reset_n = 1'b1;
        step();
        start_xfer(14'h0010, 8, 0);
        wait_done("post_rst", 200);
        chk("post_rst_cs_count", cs_cnt, 1);
        chk("post_rst_byte_count", hs_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
